muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit between regfile read and write-back.
//  Takes two operands from regfile read ports rd_1/rd_2 and computes all eight M-extension ops.
//  Uses a shift-add / restoring-divide datapath with a fixed latency.
//  Drives a one-cycle write request (werf/wa/wd) into the regfile write port.
// PARAMETERS
//  DATAWIDTH  32                    operand/result width
//  REGISTERS  32                    register count, sizes rd_addr/wa
//  INDEX      $clog2(REGISTERS)     register index width
//  CNTW       $clog2(DATAWIDTH)+1   iteration counter width
// PORTS
//  clk      in   1          clock, rising edge
//  rst_n    in   1          asynchronous active-low reset
//  start    in   1          launch op; accepted only when busy=0
//  flush    in   1          abort in-flight op (pipeline kill)
//  funct3   in   3          000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op_a     in   DATAWIDTH  rs1 value
//  op_b     in   DATAWIDTH  rs2 value
//  rd_addr  in   INDEX      destination register
//  busy     out  1          op in progress (CALC or DONE)
//  werf     out  1          one-cycle result-valid / regfile write enable
//  wa       out  INDEX      destination register, valid with werf
//  wd       out  DATAWIDTH  result, valid with werf
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy=0, werf=0, wa=0, wd=0, counter=0. Takes effect mid-op; no werf follows.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//    IDLE: on start & !flush, latch funct3, rd_addr, |op_a|/|op_b| and sign info; counter=0; go to CALC.
//    CALC: one multiply or divide step per cycle; exactly DATAWIDTH cycles; then go to DONE.
//    DONE: apply sign fixup; werf=1 for exactly one cycle with wa/wd; then go to IDLE.
//  - Latency: start in cycle T -> werf high in cycle T+DATAWIDTH+1 (cycle T+33 at default), for all ops and special cases.
//  - busy=1 from cycle T+1 through the werf cycle inclusive.
//  - start while busy=1 is ignored; the upstream stall must hold the instruction.
//  - Back-to-back: start is legal in the cycle after werf (busy=0).
//  - flush: in CALC or DONE -> IDLE next edge, werf suppressed.
//  - flush in IDLE with start: flush wins; the op is not accepted.
//  - Multiply: 2*DATAWIDTH product on magnitudes; negate if signs differ.
//    MUL returns the low half. MULH, MULHSU and MULHU return the high half.
//    Signedness: MULH s*s, MULHSU s(a)*u(b), MULHU u*u.
//  - Divide: restoring division on magnitudes; quotient sign = sa^sb; remainder sign = sign of dividend.
//  - Divide by zero: DIV/DIVU -> all-ones; REM/REMU -> op_a.
//  - Signed overflow (DIV, op_a=0x80000000, op_b=-1): quotient=0x80000000, remainder=0.
//  - rd_addr=0: werf still pulses with wa=0; the regfile discards the write.
//  - wa/wd hold their last value when werf=0; consumers qualify on werf.
// TESTING
//  - MUL 7*-3: op_a=7, op_b=0xFFFFFFFD -> werf at T+33, wd=0xFFFFFFEB, wa=rd_addr.
//  - MULH/MULHSU/MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
//  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  - DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all at T+33.
//  - Second start at T+5 ignored; flush at T+10 -> no werf, busy=0 at T+11; new start at T+11 completes at T+44.
//  - rst_n low at T+20 -> outputs 0 immediately, no werf; start with rd_addr=0 -> werf with wa=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, DATAWIDTH steps, then sign fixup and a one-cycle regfile write.
module muldiv_unit #(
    parameter int DATAWIDTH = 32,
    parameter int REGISTERS = 32,
    parameter int INDEX     = $clog2(REGISTERS),
    parameter int CNTW      = $clog2(DATAWIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 flush,
    input  logic [2:0]           funct3,
    input  logic [DATAWIDTH-1:0] op_a,
    input  logic [DATAWIDTH-1:0] op_b,
    input  logic [INDEX-1:0]     rd_addr,
    output logic                 busy,
    output logic                 werf,
    output logic [INDEX-1:0]     wa,
    output logic [DATAWIDTH-1:0] wd
);
    localparam int W = DATAWIDTH;
    localparam logic [CNTW-1:0] LP_LAST = CNTW'(DATAWIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic [2:0]      r_f3;
    logic [INDEX-1:0] r_rd;
    logic            r_sa, r_sb, r_divz;
    logic [W-1:0]    r_hi, r_lo, r_m;
    logic            r_werf;
    logic [INDEX-1:0] r_wa;
    logic [W-1:0]    r_wd;

    logic            w_a_signed, w_b_signed, w_sa, w_sb;
    logic [W-1:0]    w_mag_a, w_mag_b;
    logic [W:0]      w_add, w_shift, w_diff;
    logic [W-1:0]    w_nhi, w_nlo;
    logic [2*W-1:0]  w_prod, w_prod_s;
    logic [W-1:0]    w_q, w_r, w_rem_mag, w_result;

    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'b010:                         w_a_signed = 1'b1;
            default: ;
        endcase
        w_sa    = w_a_signed & op_a[W-1];
        w_sb    = w_b_signed & op_b[W-1];
        w_mag_a = w_sa ? -op_a : op_a;
        w_mag_b = w_sb ? -op_b : op_b;
    end

    // Multiply: r_lo holds the multiplier shifting out while the product fills {r_hi,r_lo}.
    // Divide: r_lo holds the dividend shifting into r_hi (partial remainder) and collects quotient bits.
    always_comb begin
        w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_shift = {r_hi, r_lo[W-1]};
        w_diff  = w_shift - {1'b0, r_m};
        w_nhi   = r_hi;
        w_nlo   = r_lo;
        if (!r_f3[2]) begin
            w_nhi = w_add[W:1];
            w_nlo = {w_add[0], r_lo[W-1:1]};
        end else if (!r_divz) begin
            if (!w_diff[W]) begin
                w_nhi = w_diff[W-1:0];
                w_nlo = {r_lo[W-2:0], 1'b1};
            end else begin
                w_nhi = w_shift[W-1:0];
                w_nlo = {r_lo[W-2:0], 1'b0};
            end
        end
    end

    // Divide by zero leaves |op_a| untouched in r_lo, so the signed fixup restores op_a itself.
    always_comb begin
        w_prod    = {w_nhi, w_nlo};
        w_prod_s  = (r_sa ^ r_sb) ? -w_prod : w_prod;
        w_q       = r_divz ? '1 : ((r_sa ^ r_sb) ? -w_nlo : w_nlo);
        w_rem_mag = r_divz ? w_nlo : w_nhi;
        w_r       = r_sa ? -w_rem_mag : w_rem_mag;
        case (r_f3)
            3'b000:         w_result = w_prod_s[W-1:0];
            3'b100, 3'b101: w_result = w_q;
            3'b110, 3'b111: w_result = w_r;
            default:        w_result = w_prod_s[2*W-1:W];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_f3    <= '0;
            r_rd    <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_divz  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_werf  <= 1'b0;
            r_wa    <= '0;
            r_wd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_werf <= 1'b0;
                    if (start && !flush) begin
                        r_f3    <= funct3;
                        r_rd    <= rd_addr;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_divz  <= funct3[2] & (op_b == '0);
                        r_hi    <= '0;
                        r_lo    <= funct3[2] ? w_mag_a : w_mag_b;
                        r_m     <= funct3[2] ? w_mag_b : w_mag_a;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi  <= w_nhi;
                        r_lo  <= w_nlo;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LP_LAST) begin
                            r_werf  <= 1'b1;
                            r_wa    <= r_rd;
                            r_wd    <= w_result;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_werf  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign werf = r_werf & ~flush;
    assign wa   = r_wa;
    assign wd   = r_wd;

endmodule
